// File: rtl/motion_pkg.sv
// Shared types and default tuning constants for the player vertical-motion controller.
package motion_pkg;

  typedef enum logic [1:0] {
    ST_REST = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2,
    ST_LAND = 2'd3
  } motion_state_t;

  typedef logic signed [9:0] vel_t;

  localparam int JUMP_V0_DEF     = 8;
  localparam int GRAVITY_DIV_DEF = 2;
  localparam int MAX_FALL_DEF    = 8;
  localparam int LAND_HOLD_DEF   = 6;
  localparam int VEL_ABS_MAX     = 511;

endpackage

// File: rtl/gravity_timer.sv
// Frame-tick divider: emits one step pulse every DIV enabled ticks; clear restarts the count.
module gravity_timer #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic Reset,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign step_o  = en_i & ~clr_i & at_last;

  // Next count: clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player jump/fall controller stepping once per video frame.
// Optional air jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctrl
  import motion_pkg::*;
#(
  parameter int JUMP_V0     = JUMP_V0_DEF,
  parameter int GRAVITY_DIV = GRAVITY_DIV_DEF,
  parameter int MAX_FALL    = MAX_FALL_DEF,
  parameter int LAND_HOLD   = LAND_HOLD_DEF
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       jump,
  input  logic       on_ground,
  output logic [9:0] y_motion,
  output logic       jmp,
  output logic [1:0] state_o
);

  if (JUMP_V0 < 1 || JUMP_V0 > VEL_ABS_MAX) begin : g_bad_jump_v0
    $error("JUMP_V0 must be in 1..511");
  end
  if (MAX_FALL < 1 || MAX_FALL > VEL_ABS_MAX) begin : g_bad_max_fall
    $error("MAX_FALL must be in 1..511");
  end
  if (GRAVITY_DIV < 1) begin : g_bad_grav_div
    $error("GRAVITY_DIV must be at least 1");
  end
  if (LAND_HOLD < 1) begin : g_bad_land_hold
    $error("LAND_HOLD must be at least 1");
  end

  localparam int   LW        = (LAND_HOLD > 1) ? $clog2(LAND_HOLD) : 1;
  localparam vel_t JUMP_VEL  = vel_t'(-JUMP_V0);
  localparam vel_t MAX_VEL   = vel_t'(MAX_FALL);
  localparam logic [LW-1:0] LAND_LAST = LW'(LAND_HOLD - 1);

  motion_state_t state_q;
  vel_t          vel_q;
  logic          jmp_q;
  logic          jump_prev_q;
  logic          pending_q;
  logic [LW-1:0] land_cnt_q;

  logic jump_edge;
  logic pend_now;
  logic airborne;
  logic landing;
  logic air_jump_take;
  logic grav_en;
  logic grav_clr;
  logic grav_step;
  vel_t vel_inc;

  // An edge arriving in the tick cycle itself is honoured by that tick.
  assign jump_edge = jump & ~jump_prev_q;
  assign pend_now  = pending_q | jump_edge;
  assign airborne  = (state_q == ST_RISE) || (state_q == ST_FALL);
  assign landing   = (state_q == ST_FALL) && on_ground;
  assign vel_inc   = vel_q + vel_t'(1);

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic air_used_q;

  // Air-jump eligibility: landing has priority, one air jump per flight.
  always_comb begin
    if (airborne && pend_now && !air_used_q && !landing) begin
      air_jump_take = 1'b1;
    end else begin
      air_jump_take = 1'b0;
    end
  end

  // Air jump budget, restored on touchdown.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      air_used_q <= 1'b0;
    end else if (frame_tick && landing) begin
      air_used_q <= 1'b0;
    end else if (frame_tick && air_jump_take) begin
      air_used_q <= 1'b1;
    end else begin
      air_used_q <= air_used_q;
    end
  end
`else
  assign air_jump_take = 1'b0;
`endif

  assign grav_en  = frame_tick & airborne;
  assign grav_clr = frame_tick & (~airborne | air_jump_take | landing);

  gravity_timer #(
    .DIV(GRAVITY_DIV)
  ) u_gravity_timer (
    .clk   (clk),
    .Reset (Reset),
    .en_i  (grav_en),
    .clr_i (grav_clr),
    .step_o(grav_step)
  );

  // Motion FSM with registered velocity, airborne flag and pending jump.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_REST;
      vel_q       <= '0;
      jmp_q       <= 1'b0;
      jump_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      land_cnt_q  <= '0;
    end else begin
      jump_prev_q <= jump;
      if (frame_tick) begin
        pending_q <= 1'b0;
        case (state_q)
          ST_REST: begin
            if (pend_now) begin
              vel_q   <= JUMP_VEL;
              state_q <= ST_RISE;
              jmp_q   <= 1'b1;
            end else if (!on_ground) begin
              vel_q   <= vel_t'(1);
              state_q <= ST_FALL;
              jmp_q   <= 1'b1;
            end else begin
              vel_q <= '0;
              jmp_q <= 1'b0;
            end
          end
          ST_RISE: begin
            if (air_jump_take) begin
              vel_q <= JUMP_VEL;
            end else if (grav_step) begin
              vel_q <= vel_inc;
              if (vel_inc == vel_t'(0)) begin
                state_q <= ST_FALL;
              end
            end
          end
          ST_FALL: begin
            if (landing) begin
              vel_q      <= '0;
              jmp_q      <= 1'b0;
              land_cnt_q <= '0;
              state_q    <= ST_LAND;
            end else if (air_jump_take) begin
              vel_q   <= JUMP_VEL;
              state_q <= ST_RISE;
            end else if (grav_step && (vel_q < MAX_VEL)) begin
              vel_q <= vel_inc;
            end
          end
          ST_LAND: begin
            vel_q <= '0;
            jmp_q <= 1'b0;
            if (land_cnt_q == LAND_LAST) begin
              land_cnt_q <= '0;
              state_q    <= ST_REST;
            end else begin
              land_cnt_q <= land_cnt_q + LW'(1);
            end
          end
          default: begin
            state_q <= ST_REST;
            vel_q   <= '0;
            jmp_q   <= 1'b0;
          end
        endcase
      end else begin
        pending_q <= pend_now;
      end
    end
  end

  assign y_motion = vel_q;
  assign jmp      = jmp_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with default parameters.
module tb_player_motion_ctrl;

  logic       clk;
  logic       Reset;
  logic       frame_tick;
  logic       jump;
  logic       on_ground;
  logic [9:0] y_motion;
  logic       jmp;
  logic [1:0] state_o;

  int checks;
  int failures;

  localparam int S_REST = 0;
  localparam int S_RISE = 1;
  localparam int S_FALL = 2;
  localparam int S_LAND = 3;

  player_motion_ctrl dut (
    .clk       (clk),
    .Reset     (Reset),
    .frame_tick(frame_tick),
    .jump      (jump),
    .on_ground (on_ground),
    .y_motion  (y_motion),
    .jmp       (jmp),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One frame tick: inputs driven on a falling edge, results read one falling edge later.
  task automatic do_tick(input logic og, input logic jp);
    @(negedge clk);
    on_ground  = og;
    jump       = jp;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    jump       = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int v, input int j, input int s);
    chk({tag, "_vel"}, $signed(y_motion), v);
    chk({tag, "_jmp"}, int'(jmp), j);
    chk({tag, "_st"}, int'(state_o), s);
  endtask

  initial begin
    logic mid_jump;
    int   exp_v;
    checks     = 0;
    failures   = 0;
    Reset      = 1'b1;
    frame_tick = 1'b0;
    jump       = 1'b0;
    on_ground  = 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
    mid_jump = 1'b0;
`else
    mid_jump = 1'b1;
`endif
    #12;
    chk_out("reset", 0, 0, S_REST);
    @(negedge clk);
    Reset = 1'b0;

    do_tick(1'b1, 1'b0);
    chk_out("idle", 0, 0, S_REST);

    // Edge between ticks: nothing moves until the tick.
    @(negedge clk);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("pend_hold", 0, 0, S_REST);
    do_tick(1'b1, 1'b0);
    chk_out("launch", -8, 1, S_RISE);

    // Rise; a mid-air press at tick 5 must have no effect.
    for (int n = 1; n <= 16; n++) begin
      do_tick(1'b0, mid_jump && (n == 5));
      chk("rise_vel", $signed(y_motion), -8 + n / 2);
      chk("rise_st", int'(state_o), (n >= 16) ? S_FALL : S_RISE);
    end
    chk("apex_jmp", int'(jmp), 1);

    // Fall to saturation.
    for (int n = 17; n <= 40; n++) begin
      do_tick(1'b0, 1'b0);
      exp_v = (n - 16) / 2;
      if (exp_v > 8) exp_v = 8;
      chk("fall_vel", $signed(y_motion), exp_v);
    end
    repeat (3) @(negedge clk);
    chk_out("sat_hold", 8, 1, S_FALL);

    do_tick(1'b1, 1'b0);
    chk_out("touch", 0, 0, S_LAND);
    for (int k = 1; k <= 5; k++) begin
      do_tick(1'b1, k == 2);
      if (k == 5) begin
        @(negedge clk);
        jump = 1'b1;
        @(negedge clk);
        jump = 1'b0;
      end
      chk_out("land", 0, 0, S_LAND);
    end
    do_tick(1'b1, 1'b0);
    chk_out("land_done", 0, 0, S_REST);
    do_tick(1'b1, 1'b0);
    chk_out("no_buffer", 0, 0, S_REST);

    // Walk off a ledge.
    do_tick(1'b0, 1'b0);
    chk_out("walkoff", 1, 1, S_FALL);
    do_tick(1'b1, 1'b0);
    chk_out("walk_land", 0, 0, S_LAND);
    repeat (6) do_tick(1'b1, 1'b0);
    chk_out("walk_rest", 0, 0, S_REST);

    // Edge coincident with the tick counts for that tick; then reset mid-rise.
    do_tick(1'b1, 1'b1);
    chk_out("same_cyc", -8, 1, S_RISE);
    repeat (6) do_tick(1'b0, 1'b0);
    chk_out("pre_rst", -5, 1, S_RISE);
    @(negedge clk);
    #2 Reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, S_REST);
    @(negedge clk);
    Reset = 1'b0;
    do_tick(1'b1, 1'b0);
    chk_out("post_rst", 0, 0, S_REST);

`ifdef PLAYER_DOUBLE_JUMP_EN
    do_tick(1'b1, 1'b1);
    repeat (16) do_tick(1'b0, 1'b0);
    chk_out("dj_apex", 0, 1, S_FALL);
    do_tick(1'b0, 1'b1);
    chk_out("dj_second", -8, 1, S_RISE);
    do_tick(1'b0, 1'b1);
    chk_out("dj_third", -8, 1, S_RISE);
    do_tick(1'b0, 1'b0);
    chk_out("dj_grav", -7, 1, S_RISE);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameter JUMP_V0, default 8: initial upward speed in pixels/frame, applied as -JUMP_V0.
REQ-002 Parameter GRAVITY_DIV, default 2: frame ticks per +1 velocity step, minimum 1.
REQ-003 Parameter MAX_FALL, default 8: downward velocity saturation in pixels/frame.
REQ-004 Parameter LAND_HOLD, default 6: frames spent in LAND before returning to REST.
REQ-005 clk  input  1  system clock.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_tick  input  1  one-clk pulse per video frame; all motion updates occur only on it.
REQ-008 jump  input  1  level jump button, synchronous to clk.
REQ-009 on_ground  input  1  collision flag, sampled only on frame_tick.
REQ-010 y_motion  output  10  registered signed two's-complement vertical velocity.
REQ-011 jmp  output  1  airborne flag, high in RISE and FALL.
REQ-012 state_o  output  2  current state encoding, for debug.

Function
REQ-013 States SHALL be REST, RISE, FALL, LAND; all transitions SHALL occur only in a clk cycle where frame_tick=1.
REQ-014 A rising edge of jump SHALL set a pending flag; an edge in the same cycle as frame_tick SHALL count for that tick.
REQ-015 REST with pending at tick: vel=-JUMP_V0, gravity counter cleared, go RISE, pending cleared.
REQ-016 REST, no pending, on_ground=0 at tick: vel=+1, go FALL (walk-off ledge).
REQ-017 Gravity counter: on each tick in RISE/FALL, if counter==GRAVITY_DIV-1 then vel+=1 and counter=0, else counter+=1.
REQ-018 RISE: when the tick update makes vel==0, go FALL with counter continuing.
REQ-019 FALL: vel SHALL saturate at +MAX_FALL; on_ground=1 at tick SHALL force vel=0 and go LAND, taking priority over gravity.
REQ-020 LAND: y_motion=0, jmp=0 for LAND_HOLD ticks, then REST; pending SHALL be cleared on every tick in LAND.
REQ-021 Outside REST, pending SHALL be cleared on each tick without effect (no jump buffering), except per REQ-026.
REQ-022 y_motion SHALL equal vel, updated one clk after the frame_tick cycle; it SHALL hold between ticks.
REQ-023 vel SHALL be a 10-bit signed value with no wrap; parameter checks SHALL reject JUMP_V0 or MAX_FALL > 511.

Reset
REQ-024 Reset SHALL immediately force state REST, y_motion=0, jmp=0, vel=0, pending=0, counters=0, state_o=REST, including mid-air.

Configuration
REQ-025 Macro PLAYER_DOUBLE_JUMP_EN absent: one jump per airborne period only, per REQ-021.
REQ-026 Macro PLAYER_DOUBLE_JUMP_EN defined: one pending jump consumed at a RISE/FALL tick SHALL set vel=-JUMP_V0, clear counter, go RISE, and set air_used; air_used SHALL block further air jumps and clear on entering LAND.

Structure
REQ-027 Package motion_pkg SHALL hold the state enum, the 10-bit velocity typedef, and default parameter constants.
REQ-028 Sub-module gravity_timer SHALL implement the GRAVITY_DIV tick counter with clear and step-pulse output.

Verification
REQ-029 Defaults; jump edge, then tick -> y_motion=-8, jmp=1 next clk; at tick 2 -> -7; at tick 16 -> 0, state FALL.
REQ-030 Continue falling with on_ground=0 -> y_motion saturates at +8 and holds; on_ground=1 at tick -> y_motion=0, LAND, then REST after 6 ticks.
REQ-031 Jump pressed in LAND or mid-air (macro off) -> no velocity change; REST reached with pending=0.
REQ-032 REST with on_ground=0 at tick -> y_motion=+1, jmp=1, state FALL.
REQ-033 Reset asserted at RISE vel -5 -> y_motion=0, jmp=0 asynchronously; after release, a tick with no jump -> remains REST.
REQ-034 Macro on: second jump in FALL -> y_motion=-8; third jump ignored until LAND.
